// File: rtl/cpu_state_dump.sv
// Debug readout engine: streams register-file words, then data-memory bytes, as valid/ready records.
// Latency: first record valid 2 edges after start. Backpressure: a single output slot, held stable while ready is low.
module cpu_state_dump #(
  parameter int REG_COUNT = 32,
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [6:0]  mem_addr_o,
  input  logic [7:0]  mem_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic        dump_kind_o,
  output logic [4:0]  dump_index_o,
  output logic [31:0] dump_data_o
);

  localparam logic [6:0] LAST    = 7'(REG_COUNT + MEM_BYTES - 1);
  localparam logic [6:0] REG_END = 7'(REG_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [6:0] ptr;
  logic [6:0] mem_off;
  logic       is_reg;
  logic       load;
  logic       hshk;

  always_comb begin
    is_reg     = (ptr < REG_END);
    mem_off    = ptr - REG_END;
    load       = (state == RUN) && (!dump_valid_o || dump_ready_i);
    hshk       = dump_valid_o && dump_ready_i;
    rf_addr_o  = '0;
    mem_addr_o = '0;
    // Debug read addresses are only driven while records are still being fetched.
    if (state == RUN) begin
      if (is_reg) rf_addr_o = ptr[4:0];
      else        mem_addr_o = mem_off;
    end
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (load && ptr == LAST) state_nxt = DRAIN;
      DRAIN:   if (hshk) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dump_valid_o <= 1'b0;
      dump_kind_o  <= 1'b0;
      dump_index_o <= '0;
      dump_data_o  <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE && start_i) begin
        ptr    <= '0;
        busy_o <= 1'b1;
      end
      if (load) begin
        // Read data is captured here, so writes landing before this edge are visible.
        dump_valid_o <= 1'b1;
        dump_kind_o  <= !is_reg;
        dump_index_o <= is_reg ? ptr[4:0] : mem_off[4:0];
        dump_data_o  <= is_reg ? rf_data_i : {24'b0, mem_data_i};
        ptr          <= ptr + 7'd1;
      end else if (state == DRAIN && hshk) begin
        dump_valid_o <= 1'b0;
        busy_o       <= 1'b0;
        done_o       <= 1'b1;
      end
    end
  end

endmodule
